// File: rtl/riscv_rvalid_stall_pkg.sv
// Stall-mode constants and the default response entry for the R-channel stall stage.
// STANDARD uses a fixed delay, RANDOM draws one per response, other modes mean no delay.
package perturbation_defines;

  localparam logic [31:0] STANDARD = 32'd0;
  localparam logic [31:0] RANDOM   = 32'd1;

  localparam int unsigned RSP_DATA_W = 32;
  localparam int unsigned RSP_CNT_W  = 32;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] data;
    logic                  err;
    logic [RSP_CNT_W-1:0]  delay;
  } rsp_entry_t;

endpackage

// File: rtl/riscv_rvalid_stall_fifo.sv
// In-order FIFO of response entries; exposes head and the entry behind it.
// Ports: push_i/data_i write, pop_i read, head_o/next_o, full_o, empty_o, count_o.
module riscv_rvalid_stall_fifo
  import perturbation_defines::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = rsp_entry_t,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  entry_t        data_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output entry_t        next_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;

  assign do_pop  = pop_i && !empty_o;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign do_push = push_i && (!full_o || do_pop);

  assign head_o = mem_q[rd_q];
  assign next_o = mem_q[rd_q + PW'(1)];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/riscv_rvalid_stall.sv
// OBI R-channel stall: buffers memory responses, releases each after a per-entry delay.
// Build macro RVALID_STALL_XDATA_EN drives random rdata/err while rvalid_core_o is low.
module riscv_rvalid_stall
  import perturbation_defines::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rvalid_mem_i,
  input  logic [DATA_WIDTH-1:0] rdata_mem_i,
  input  logic                  err_mem_i,
  output logic                  rvalid_core_o,
  output logic [DATA_WIDTH-1:0] rdata_core_o,
  output logic                  err_core_o,
  input  logic                  en_stall_i,
  input  logic [31:0]           stall_mode_i,
  input  logic [31:0]           max_stall_i,
  input  logic [31:0]           rvalid_stall_i,
  output logic                  full_o,
  output logic                  overflow_o,
  output logic [OW-1:0]         outstanding_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
    logic [CNT_WIDTH-1:0]  delay;
  } entry_t;

  entry_t               push_e;
  entry_t               head_e;
  entry_t               next_e;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic [OW-1:0]        count;
  logic [CNT_WIDTH-1:0] head_cnt_q;
  logic [CNT_WIDTH-1:0] delay_sel;
  logic [31:0]          rnd_q;
  logic [31:0]          rnd_mod;
  logic                 ovf_q;
  logic                 unused_fields;

  // 33-bit divisor so max_stall_i = 2^32-1 still yields a full range
  assign rnd_mod = 32'({1'b0, rnd_q} % ({1'b0, max_stall_i} + 33'd1));

  always_comb begin
    delay_sel = '0;
    if (en_stall_i) begin
      case (stall_mode_i)
        STANDARD: delay_sel = CNT_WIDTH'(rvalid_stall_i);
        RANDOM:   delay_sel = CNT_WIDTH'(rnd_mod);
        default:  delay_sel = '0;
      endcase
    end
  end

  assign push_e = '{data: rdata_mem_i, err: err_mem_i, delay: delay_sel};

  riscv_rvalid_stall_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rvalid_mem_i),
    .data_i  (push_e),
    .pop_i   (pop),
    .head_o  (head_e),
    .next_o  (next_e),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign unused_fields = ^{next_e.data, next_e.err, head_e.delay};

  assign pop = !empty && (head_cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_cnt_q <= '0;
      ovf_q      <= 1'b0;
      rnd_q      <= '0;
    end else begin
      rnd_q <= $urandom();
      // the counter always holds the remaining delay of whichever entry is head
      if (pop) begin
        if (count > OW'(1)) begin
          head_cnt_q <= next_e.delay;
        end else if (rvalid_mem_i) begin
          head_cnt_q <= delay_sel;
        end
      end else if (empty && rvalid_mem_i) begin
        head_cnt_q <= delay_sel;
      end else if (head_cnt_q != '0) begin
        head_cnt_q <= head_cnt_q - CNT_WIDTH'(1);
      end
      if (rvalid_mem_i && full && !pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign rvalid_core_o = pop;
  assign full_o        = full;
  assign overflow_o    = ovf_q;
  assign outstanding_o = count;

`ifdef RVALID_STALL_XDATA_EN
  logic [DATA_WIDTH-1:0] xdata_q;
  logic                  xerr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xdata_q <= '0;
      xerr_q  <= 1'b0;
    end else begin
      xdata_q <= DATA_WIDTH'($urandom());
      xerr_q  <= 1'($urandom());
    end
  end

  assign rdata_core_o = pop ? head_e.data : xdata_q;
  assign err_core_o   = pop ? head_e.err  : xerr_q;
`else
  assign rdata_core_o = pop ? head_e.data : '0;
  assign err_core_o   = pop ? head_e.err  : 1'b0;
`endif

endmodule

// File: tb/tb_riscv_rvalid_stall.sv
// Randomised self-checking bench for riscv_rvalid_stall.
// Reference: per-response due cycle = max(push+1, previous due+1) + delay.
module tb_riscv_rvalid_stall;
  import perturbation_defines::*;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rvalid_mem_i = 1'b0;
  logic [31:0] rdata_mem_i = '0;
  logic        err_mem_i = 1'b0;
  logic        rvalid_core_o;
  logic [31:0] rdata_core_o;
  logic        err_core_o;
  logic        en_stall_i = 1'b0;
  logic [31:0] stall_mode_i = '0;
  logic [31:0] max_stall_i = '0;
  logic [31:0] rvalid_stall_i = '0;
  logic        full_o;
  logic        overflow_o;
  logic [2:0]  outstanding_o;

  riscv_rvalid_stall #(
    .FIFO_DEPTH (DEPTH),
    .DATA_WIDTH (32),
    .CNT_WIDTH  (32)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .rvalid_mem_i   (rvalid_mem_i),
    .rdata_mem_i    (rdata_mem_i),
    .err_mem_i      (err_mem_i),
    .rvalid_core_o  (rvalid_core_o),
    .rdata_core_o   (rdata_core_o),
    .err_core_o     (err_core_o),
    .en_stall_i     (en_stall_i),
    .stall_mode_i   (stall_mode_i),
    .max_stall_i    (max_stall_i),
    .rvalid_stall_i (rvalid_stall_i),
    .full_o         (full_o),
    .overflow_o     (overflow_o),
    .outstanding_o  (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  int   last_due = -10;
  bit   m_ovf = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic logic [38:0] model_vec();
    bit         v;
    logic [2:0] n;
    v = q.size() > 0 && q[0].due == cyc;
    n = 3'(q.size());
    return {v, v ? q[0].data : 32'h0, v ? q[0].err : 1'b0,
            n, n == 3'(DEPTH), m_ovf};
  endfunction

  function automatic logic [38:0] obs_vec();
    logic [31:0] d;
    logic        e;
    d = rdata_core_o;
    e = err_core_o;
`ifdef RVALID_STALL_XDATA_EN
    if (!rvalid_core_o) begin
      d = '0;
      e = 1'b0;
    end
`endif
    return {rvalid_core_o, d, e, outstanding_o, full_o, overflow_o};
  endfunction

  task automatic advance(input bit v, input logic [31:0] d,
                         input bit e, input int dly);
    bit   pop;
    int   n;
    exp_t x;
    n = q.size();
    pop = n > 0 && q[0].due == cyc;
    if (pop) void'(q.pop_front());
    if (v) begin
      if (n < DEPTH || pop) begin
        x.data = d;
        x.err = e;
        x.due = ((cyc + 1 > last_due + 1) ? cyc + 1 : last_due + 1) + dly;
        last_due = x.due;
        q.push_back(x);
      end else begin
        m_ovf = 1'b1;
      end
    end
    rvalid_mem_i = v;
    rdata_mem_i = d;
    err_mem_i = e;
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    rvalid_mem_i = 1'b0;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    last_due = -10;
  endtask

  task automatic test_reset();
    logic [38:0] o;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    o = obs_vec();
    n_tests++;
    if (o !== 39'h0 || rdata_core_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset got=%h rdata=%h want=0", o, rdata_core_o);
    end
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_single();
    logic [38:0] e, o;
    int nv = 0;
    en_stall_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      e = model_vec();
      o = obs_vec();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL single i=%0d got=%h want=%h", i, o, e);
      end
      if (rvalid_core_o) nv++;
      advance(i == 10, (i == 10) ? 32'hDEADBEEF : $urandom(), 1'b0, 0);
    end
    n_tests++;
    if (nv !== 1) begin
      n_fail++;
      $display("FAIL single_count got=%0d want=1", nv);
    end
  endtask

  task automatic test_standard();
    logic [38:0] e, o;
    int va = -1, vb = -1;
    en_stall_i = 1'b1;
    stall_mode_i = STANDARD;
    rvalid_stall_i = 32'd3;
    for (int i = 0; i < 25; i++) begin
      e = model_vec();
      o = obs_vec();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL standard i=%0d got=%h want=%h", i, o, e);
      end
      if (rvalid_core_o) begin
        if (va < 0) va = i;
        else vb = i;
      end
      advance(i == 10 || i == 11, 32'hA000_0000 + 32'(i), 1'(i & 1), 3);
    end
    n_tests++;
    if (va !== 14 || vb !== 18) begin
      n_fail++;
      $display("FAIL standard_cycles got=%0d,%0d want=14,18", va, vb);
    end
  endtask

  task automatic test_back_to_back();
    logic [38:0] e, o;
    int peak = 0, first = -1;
    en_stall_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      e = model_vec();
      o = obs_vec();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b i=%0d got=%h want=%h", i, o, e);
      end
      if (int'(outstanding_o) > peak) peak = int'(outstanding_o);
      if (rvalid_core_o && first < 0) first = i;
      advance(i >= 2 && i <= 5, $urandom(), 1'($urandom()), 0);
    end
    n_tests++;
    if (peak !== 1 || first !== 3) begin
      n_fail++;
      $display("FAIL b2b_peak got=%0d/%0d want=1/3", peak, first);
    end
  endtask

  task automatic test_random_fixed();
    logic [38:0] e, o;
    int r, dly;
    bit v;
    reset_dut();
    for (int i = 0; i < 460; i++) begin
      e = model_vec();
      o = obs_vec();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rand_fixed i=%0d got=%h want=%h", i, o, e);
      end
      r = int'($urandom_range(0, 3));
      rvalid_stall_i = $urandom_range(0, 4);
      en_stall_i = (r != 0);
      stall_mode_i = (r == 2) ? 32'd7 : STANDARD;
      dly = (r == 1 || r == 3) ? int'(rvalid_stall_i) : 0;
      v = (i < 400) && ($urandom_range(0, 2) != 0);
      advance(v, $urandom(), 1'($urandom()), dly);
    end
  endtask

  task automatic test_overflow();
    logic [38:0] e, o;
    int nv = 0, ff = -1, fo = -1;
    reset_dut();
    en_stall_i = 1'b1;
    stall_mode_i = STANDARD;
    rvalid_stall_i = 32'd20;
    for (int i = 0; i < 100; i++) begin
      e = model_vec();
      o = obs_vec();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL overflow i=%0d got=%h want=%h", i, o, e);
      end
      if (rvalid_core_o) nv++;
      if (full_o && ff < 0) ff = i;
      if (overflow_o && fo < 0) fo = i;
      advance(i >= 10 && i <= 14, 32'hC0DE_0000 + 32'(i), 1'b0, 20);
    end
    n_tests++;
    if (nv !== 4 || ff !== 14 || fo !== 15) begin
      n_fail++;
      $display("FAIL overflow_sum got=%0d/%0d/%0d want=4/14/15", nv, ff, fo);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          pc;
  } rq_t;

  task automatic test_random_mode();
    rq_t rq[$];
    rq_t x;
    bit  hit [6];
    int  sent = 0, last_del = -10, hs, lat, i = 0;
    bit  stop = 1'b0;
    reset_dut();
    en_stall_i = 1'b1;
    stall_mode_i = RANDOM;
    max_stall_i = 32'd5;
    foreach (hit[k]) hit[k] = 1'b0;
    while (!stop && (sent < 1000 || rq.size() > 0)) begin
      if (rq.size() > 0) begin
        hs = (rq[0].pc + 1 > last_del + 1) ? rq[0].pc + 1 : last_del + 1;
        lat = cyc - hs;
        if (rvalid_core_o) begin
          n_tests++;
          if (rdata_core_o !== rq[0].data || err_core_o !== rq[0].err
              || lat < 0 || lat > 5) begin
            n_fail++;
            $display("FAIL random got=%h/%0d want=%h lat<=5",
                     rdata_core_o, lat, rq[0].data);
          end else begin
            hit[lat] = 1'b1;
          end
          void'(rq.pop_front());
          last_del = cyc;
        end else if (lat > 5) begin
          n_tests++;
          n_fail++;
          $display("FAIL random_timeout lat=%0d want<=5", lat);
          stop = 1'b1;
        end
      end else if (rvalid_core_o) begin
        n_tests++;
        n_fail++;
        $display("FAIL random_spurious got=1 want=0");
      end
      x.data = $urandom();
      x.err = 1'($urandom());
      x.pc = cyc;
      if (!stop && sent < 1000 && rq.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        rq.push_back(x);
        sent++;
        rvalid_mem_i = 1'b1;
      end else begin
        rvalid_mem_i = 1'b0;
      end
      rdata_mem_i = x.data;
      err_mem_i = x.err;
      @(posedge clk_i);
      #1;
      i++;
      if (i > 20000) begin
        n_tests++;
        n_fail++;
        $display("FAIL random_budget sent=%0d want=1000", sent);
        stop = 1'b1;
      end
    end
    rvalid_mem_i = 1'b0;
    n_tests++;
    if (!(hit[0] && hit[1] && hit[2] && hit[3] && hit[4] && hit[5])
        || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL random_cover got=%b%b%b%b%b%b ovf=%b want=111111 ovf=0",
               hit[0], hit[1], hit[2], hit[3], hit[4], hit[5], overflow_o);
    end
  endtask

  task automatic test_reset_flush();
    logic [38:0] e, o;
    reset_dut();
    en_stall_i = 1'b1;
    stall_mode_i = STANDARD;
    rvalid_stall_i = 32'd10;
    for (int i = 0; i < 5; i++) begin
      advance(i < 3, $urandom(), 1'b1, 10);
    end
    n_tests++;
    if (outstanding_o !== 3'd3) begin
      n_fail++;
      $display("FAIL flush_pre got=%0d want=3", outstanding_o);
    end
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({rvalid_core_o, rdata_core_o, err_core_o, outstanding_o,
         full_o, overflow_o} !== 39'h0) begin
      n_fail++;
      $display("FAIL flush_async got=%b/%0d want=0/0",
               rvalid_core_o, outstanding_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < 30; i++) begin
      e = model_vec();
      o = obs_vec();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL flush i=%0d got=%h want=%h", i, o, e);
      end
      advance(1'b0, $urandom(), 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_standard();
    test_back_to_back();
    test_random_fixed();
    test_overflow();
    test_random_mode();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
